// File: rtl/riscv_v_pkg.sv
// Shared vector-unit types: register-file addressing, ALU result payload and write-back entry.
package riscv_v_pkg;

  localparam int unsigned RISCV_V_RF_NUM_REGS   = 32;
  localparam int unsigned RISCV_V_VLEN          = 128;
  localparam int unsigned RISCV_V_VLENB         = RISCV_V_VLEN / 8;
  localparam int unsigned RISCV_V_WB_FIFO_DEPTH = 2;
  localparam int unsigned RISCV_V_SB_CNT_W      = 2;

  typedef logic [$clog2(RISCV_V_RF_NUM_REGS)-1:0] riscv_v_rf_addr_t;
  typedef logic [RISCV_V_VLEN-1:0]                riscv_v_data_t;
  typedef logic [RISCV_V_VLENB-1:0]               riscv_v_rf_wr_en_t;

  typedef struct packed {
    riscv_v_data_t     data;
    riscv_v_rf_wr_en_t merge;
    riscv_v_rf_wr_en_t valid;
  } riscv_v_alu_data_t;

  typedef struct packed {
    riscv_v_rf_addr_t  addr;
    riscv_v_rf_wr_en_t en;
    riscv_v_data_t     data;
  } riscv_v_wb_entry_t;

endpackage

// File: rtl/riscv_v_sync_fifo.sv
// Single-clock circular FIFO with occupancy count; push is ignored when full, pop when empty.
module riscv_v_sync_fifo #(
  parameter type         T     = logic,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  T                             wdata,
  input  logic                         pop,
  output T                             rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  T                 mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/riscv_v_wb_stage.sv
// Vector write-back stage: buffers ALU results, drives the regfile write port and
// tracks outstanding writes per register for decode RAW checks.
module riscv_v_wb_stage
  import riscv_v_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = RISCV_V_WB_FIFO_DEPTH,
  parameter int unsigned NUM_REGS   = RISCV_V_RF_NUM_REGS,
  parameter int unsigned SB_CNT_W   = RISCV_V_SB_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid_i,
  output logic              alu_ready_o,
  input  riscv_v_alu_data_t alu_data_i,
  input  riscv_v_rf_addr_t  alu_addr_i,
  input  logic              issue_valid_i,
  input  riscv_v_rf_addr_t  issue_addr_i,
  input  riscv_v_rf_addr_t  query_addr_i,
  output logic              query_busy_o,
  output riscv_v_rf_addr_t  rf_wr_addr_o,
  output riscv_v_rf_wr_en_t rf_wr_en_o,
  output riscv_v_data_t     rf_wr_data_o,
  input  logic              rf_wr_stall_i,
  output logic              sb_overflow_o
);

  localparam int unsigned FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

  riscv_v_wb_entry_t     push_entry;
  riscv_v_wb_entry_t     head_entry;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [FIFO_CNT_W-1:0] fifo_count_unused;
  logic                  push;
  logic                  load;
  logic                  out_valid_q;
  logic                  wr_done;

  logic [SB_CNT_W-1:0]   cnt_q [NUM_REGS];
  logic [SB_CNT_W-1:0]   cnt_d [NUM_REGS];
  logic                  ovf_set;

  assign alu_ready_o = ~fifo_full;
  assign push        = alu_valid_i & ~fifo_full;
  assign wr_done     = out_valid_q & ~rf_wr_stall_i;
  assign load        = (~out_valid_q | wr_done) & ~fifo_empty;

  always_comb begin
    push_entry      = '0;
    push_entry.addr = alu_addr_i;
    push_entry.en   = alu_data_i.valid & ~alu_data_i.merge;
    push_entry.data = alu_data_i.data;
  end

  riscv_v_sync_fifo #(
    .T     (riscv_v_wb_entry_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (push_entry),
    .pop   (load),
    .rdata (head_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count_unused)
  );

  // Output slot; the enable register is cleared when the slot drains so it reads 0 when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      rf_wr_addr_o <= '0;
      rf_wr_en_o   <= '0;
      rf_wr_data_o <= '0;
    end else if (load) begin
      out_valid_q  <= 1'b1;
      rf_wr_addr_o <= head_entry.addr;
      rf_wr_en_o   <= head_entry.en;
      rf_wr_data_o <= head_entry.data;
    end else if (wr_done) begin
      out_valid_q  <= 1'b0;
      rf_wr_en_o   <= '0;
    end
  end

  // Scoreboard: coincident issue and completion on one register cancel out.
  always_comb begin
    ovf_set = 1'b0;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = cnt_q[r];
      if (issue_valid_i && (issue_addr_i == riscv_v_rf_addr_t'(r)) &&
          !(wr_done && (rf_wr_addr_o == riscv_v_rf_addr_t'(r)))) begin
        if (cnt_q[r] == {SB_CNT_W{1'b1}}) ovf_set = 1'b1;
        else                              cnt_d[r] = cnt_q[r] + SB_CNT_W'(1);
      end else if (wr_done && (rf_wr_addr_o == riscv_v_rf_addr_t'(r)) &&
                   !(issue_valid_i && (issue_addr_i == riscv_v_rf_addr_t'(r)))) begin
        if (cnt_q[r] != '0) cnt_d[r] = cnt_q[r] - SB_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
      sb_overflow_o <= 1'b0;
    end else begin
      for (int unsigned r = 0; r < NUM_REGS; r++) cnt_q[r] <= cnt_d[r];
      sb_overflow_o <= sb_overflow_o | ovf_set;
    end
  end

  assign query_busy_o = (cnt_q[query_addr_i] != '0);

endmodule

// File: tb/tb_riscv_v_wb_stage.sv
// Directed bench for riscv_v_wb_stage: latency, scoreboard, stall/backpressure and reset.
module tb_riscv_v_wb_stage;
  import riscv_v_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              alu_valid;
  logic              alu_ready;
  riscv_v_alu_data_t alu_data;
  riscv_v_rf_addr_t  alu_addr;
  logic              issue_valid;
  riscv_v_rf_addr_t  issue_addr;
  riscv_v_rf_addr_t  query_addr;
  logic              query_busy;
  riscv_v_rf_addr_t  rf_wr_addr;
  riscv_v_rf_wr_en_t rf_wr_en;
  riscv_v_data_t     rf_wr_data;
  logic              stall;
  logic              sb_overflow;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  riscv_v_wb_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .alu_valid_i   (alu_valid),
    .alu_ready_o   (alu_ready),
    .alu_data_i    (alu_data),
    .alu_addr_i    (alu_addr),
    .issue_valid_i (issue_valid),
    .issue_addr_i  (issue_addr),
    .query_addr_i  (query_addr),
    .query_busy_o  (query_busy),
    .rf_wr_addr_o  (rf_wr_addr),
    .rf_wr_en_o    (rf_wr_en),
    .rf_wr_data_o  (rf_wr_data),
    .rf_wr_stall_i (stall),
    .sb_overflow_o (sb_overflow)
  );

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_beat(input logic v, input riscv_v_rf_addr_t a, input riscv_v_data_t d,
                          input riscv_v_rf_wr_en_t vld, input riscv_v_rf_wr_en_t mrg);
    alu_valid      = v;
    alu_addr       = a;
    alu_data.data  = d;
    alu_data.valid = vld;
    alu_data.merge = mrg;
  endtask

  task automatic test_reset();
    #12;
    total++; if (rf_wr_en !== '0)   begin bad++; $display("FAIL reset_en got=%h exp=0", rf_wr_en); end
    total++; if (rf_wr_addr !== '0) begin bad++; $display("FAIL reset_addr got=%0d exp=0", rf_wr_addr); end
    total++; if (rf_wr_data !== '0) begin bad++; $display("FAIL reset_data got=%h exp=0", rf_wr_data); end
    total++; if (sb_overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", sb_overflow); end
    rst_n = 1'b1;
    #1;
    total++; if (alu_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", alu_ready); end
    for (int a = 0; a < 32; a++) begin
      query_addr = riscv_v_rf_addr_t'(a);
      @(negedge clk);
      total++; if (query_busy !== 1'b0) begin bad++; $display("FAIL reset_busy addr=%0d got=%b exp=0", a, query_busy); end
    end
    step();
  endtask

  task automatic test_single();
    riscv_v_data_t d = 128'h0F0E0D0C0B0A09080706050403020100;
    set_beat(1'b1, 5'd5, d, 16'hFFFF, 16'h00F0);
    step();
    alu_valid = 1'b0;
    total++; if (rf_wr_en !== '0) begin bad++; $display("FAIL single_early_en got=%h exp=0", rf_wr_en); end
    step();
    total++; if (rf_wr_en !== 16'hFF0F) begin bad++; $display("FAIL single_en got=%h exp=ff0f", rf_wr_en); end
    total++; if (rf_wr_addr !== 5'd5)   begin bad++; $display("FAIL single_addr got=%0d exp=5", rf_wr_addr); end
    total++; if (rf_wr_data !== d)      begin bad++; $display("FAIL single_data got=%h exp=%h", rf_wr_data, d); end
    step();
    total++; if (rf_wr_en !== '0)     begin bad++; $display("FAIL single_idle_en got=%h exp=0", rf_wr_en); end
    total++; if (rf_wr_addr !== 5'd5) begin bad++; $display("FAIL single_hold_addr got=%0d exp=5", rf_wr_addr); end
    total++; if (rf_wr_data !== d)    begin bad++; $display("FAIL single_hold_data got=%h exp=%h", rf_wr_data, d); end
  endtask

  task automatic test_raw();
    query_addr  = 5'd7;
    issue_valid = 1'b1;
    issue_addr  = 5'd7;
    step();
    total++; if (query_busy !== 1'b1) begin bad++; $display("FAIL raw_busy_issue1 got=%b exp=1", query_busy); end
    step();
    issue_valid = 1'b0;
    set_beat(1'b1, 5'd7, 128'h77, 16'hFFFF, 16'h0000);
    step();
    set_beat(1'b1, 5'd7, 128'h78, 16'hFFFF, 16'h0000);
    step();
    alu_valid = 1'b0;
    total++; if (rf_wr_data !== 128'h77) begin bad++; $display("FAIL raw_first_data got=%h exp=77", rf_wr_data); end
    step();
    total++; if (query_busy !== 1'b1) begin bad++; $display("FAIL raw_busy_after_w1 got=%b exp=1", query_busy); end
    total++; if (rf_wr_data !== 128'h78) begin bad++; $display("FAIL raw_second_data got=%h exp=78", rf_wr_data); end
    step();
    total++; if (query_busy !== 1'b0) begin bad++; $display("FAIL raw_busy_after_w2 got=%b exp=0", query_busy); end
    total++; if (rf_wr_en !== '0) begin bad++; $display("FAIL raw_idle_en got=%h exp=0", rf_wr_en); end
  endtask

  task automatic test_back_to_back_stall();
    riscv_v_data_t d [4];
    int   idx = 0;
    logic acc;
    for (int i = 0; i < 4; i++) d[i] = riscv_v_data_t'(128'hA0 + i);
    stall = 1'b1;
    for (int c = 0; c < 6; c++) begin
      set_beat(idx < 4, 5'd10, d[idx], 16'hFFFF, 16'h0000);
      acc = alu_valid & alu_ready;
      step();
      if (acc) idx++;
    end
    total++; if (idx !== 3)          begin bad++; $display("FAIL stall_accepted got=%0d exp=3", idx); end
    total++; if (alu_ready !== 1'b0) begin bad++; $display("FAIL stall_ready got=%b exp=0", alu_ready); end
    total++; if (rf_wr_en !== 16'hFFFF) begin bad++; $display("FAIL stall_en got=%h exp=ffff", rf_wr_en); end
    total++; if (rf_wr_data !== d[0])   begin bad++; $display("FAIL stall_hold_data got=%h exp=%h", rf_wr_data, d[0]); end
    stall = 1'b0;
    for (int k = 1; k < 4; k++) begin
      if (idx < 4) set_beat(1'b1, 5'd10, d[idx], 16'hFFFF, 16'h0000);
      else         alu_valid = 1'b0;
      acc = alu_valid & alu_ready;
      step();
      if (acc) idx++;
      total++; if (rf_wr_data !== d[k] || rf_wr_en !== 16'hFFFF) begin
        bad++; $display("FAIL release_order k=%0d got=%h/%h exp=%h/ffff", k, rf_wr_data, rf_wr_en, d[k]);
      end
    end
    alu_valid = 1'b0;
    total++; if (idx !== 4) begin bad++; $display("FAIL release_accept4 got=%0d exp=4", idx); end
    step();
    total++; if (rf_wr_en !== '0) begin bad++; $display("FAIL release_idle_en got=%h exp=0", rf_wr_en); end
  endtask

  task automatic test_same_cycle();
    query_addr  = 5'd3;
    issue_valid = 1'b1;
    issue_addr  = 5'd3;
    set_beat(1'b1, 5'd3, 128'h33, 16'hFFFF, 16'h0000);
    step();
    issue_valid = 1'b0;
    alu_valid   = 1'b0;
    step();
    issue_valid = 1'b1;
    total++; if (rf_wr_addr !== 5'd3 || rf_wr_en !== 16'hFFFF) begin
      bad++; $display("FAIL same_slot got=%0d/%h exp=3/ffff", rf_wr_addr, rf_wr_en);
    end
    step();
    issue_valid = 1'b0;
    total++; if (query_busy !== 1'b1) begin bad++; $display("FAIL same_cycle_busy got=%b exp=1", query_busy); end
    set_beat(1'b1, 5'd3, 128'h34, 16'h00FF, 16'h00FF);
    step();
    alu_valid = 1'b0;
    step();
    total++; if (rf_wr_en !== '0 || rf_wr_data !== 128'h34) begin
      bad++; $display("FAIL zero_en_slot got=%h/%h exp=0/34", rf_wr_en, rf_wr_data);
    end
    step();
    total++; if (query_busy !== 1'b0) begin bad++; $display("FAIL zero_en_drain got=%b exp=0", query_busy); end
  endtask

  task automatic test_overflow();
    query_addr  = 5'd9;
    issue_valid = 1'b1;
    issue_addr  = 5'd9;
    step(); step(); step();
    total++; if (sb_overflow !== 1'b0) begin bad++; $display("FAIL ovf_early got=%b exp=0", sb_overflow); end
    step();
    issue_valid = 1'b0;
    total++; if (sb_overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", sb_overflow); end
    for (int i = 0; i < 3; i++) begin
      set_beat(1'b1, 5'd9, riscv_v_data_t'(128'h90 + i), 16'hFFFF, 16'h0000);
      step();
    end
    alu_valid = 1'b0;
    step();
    total++; if (query_busy !== 1'b1) begin bad++; $display("FAIL ovf_one_left got=%b exp=1", query_busy); end
    step();
    total++; if (query_busy !== 1'b0) begin bad++; $display("FAIL ovf_drained got=%b exp=0", query_busy); end
    total++; if (sb_overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", sb_overflow); end
  endtask

  task automatic test_reset_mid();
    stall       = 1'b1;
    issue_valid = 1'b1;
    issue_addr  = 5'd12;
    for (int i = 0; i < 4; i++) begin
      set_beat(1'b1, 5'd12, riscv_v_data_t'(128'hC0 + i), 16'hFFFF, 16'h0000);
      step();
    end
    issue_valid = 1'b0;
    alu_valid   = 1'b0;
    total++; if (alu_ready !== 1'b0 || rf_wr_en !== 16'hFFFF) begin
      bad++; $display("FAIL pre_reset got=%b/%h exp=0/ffff", alu_ready, rf_wr_en);
    end
    #1;
    rst_n = 1'b0;
    #1;
    total++; if (rf_wr_en !== '0) begin bad++; $display("FAIL mid_reset_en got=%h exp=0", rf_wr_en); end
    total++; if (sb_overflow !== 1'b0) begin bad++; $display("FAIL mid_reset_ovf got=%b exp=0", sb_overflow); end
    #3;
    rst_n = 1'b1;
    stall = 1'b0;
    #1;
    total++; if (alu_ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready got=%b exp=1", alu_ready); end
    for (int a = 0; a < 32; a++) begin
      query_addr = riscv_v_rf_addr_t'(a);
      @(negedge clk);
      total++; if (query_busy !== 1'b0 || rf_wr_en !== '0) begin
        bad++; $display("FAIL post_reset addr=%0d busy=%b en=%h exp=0/0", a, query_busy, rf_wr_en);
      end
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    alu_valid   = 1'b0;
    alu_data    = '0;
    alu_addr    = '0;
    issue_valid = 1'b0;
    issue_addr  = '0;
    query_addr  = '0;
    stall       = 1'b0;
    test_reset();
    test_single();
    test_raw();
    test_back_to_back_stall();
    test_same_cycle();
    test_overflow();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
